// File: rtl/stack_ctrl_if.sv
// rtl/stack_ctrl_if.sv - stack memory bus between stack_ctrl and a 2R/1W stack RAM
//
// Purpose: groups the stack memory's read and write ports.
//   master (controller) drives: mem_dout_addr0, mem_dout_addr1, we, mem_din_addr, mem_din
//   master receives:             mem_dout0, mem_dout1 (async read data)
//   slave (memory) sees the opposite directions.
interface stack_ctrl_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] mem_dout_addr0;
  logic [WIDTH-1:0] mem_dout_addr1;
  logic [15:0]      mem_dout0;
  logic [15:0]      mem_dout1;
  logic             we;
  logic [WIDTH-1:0] mem_din_addr;
  logic [15:0]      mem_din;

  modport master (
    output mem_dout_addr0, mem_dout_addr1, we, mem_din_addr, mem_din,
    input  mem_dout0, mem_dout1
  );

  modport slave (
    input  mem_dout_addr0, mem_dout_addr1, we, mem_din_addr, mem_din,
    output mem_dout0, mem_dout1
  );
endinterface

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - stack pointer / depth control unit for the CPU data stack
//
// Purpose: owns sp and depth, drives the stack RAM ports, returns TOS/NOS and
// traps illegal ops into a sticky FAULT state until clear.
// Ports:
//   clk, reset        clock, async active-high reset
//   op_valid, op      op strobe and code (0 NOP,1 PUSH,2 POP,3 BINOP,4 REPLACE)
//   data_in           write value for PUSH/BINOP/REPLACE
//   clear             leave FAULT / clear err; also discards a same-cycle op
//   tos, nos          values at sp-1 / sp-2 from the async read ports
//   depth, empty,full words on stack and its limits
//   fault, err        FAULT state flag, 01 overflow / 10 underflow
//   mem               stack RAM bus (master side)
module stack_ctrl #(
  parameter int WIDTH = 6,
  parameter int SIZE  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [15:0]      data_in,
  input  logic             clear,
  output logic [15:0]      tos,
  output logic [15:0]      nos,
  output logic [WIDTH:0]   depth,
  output logic             empty,
  output logic             full,
  output logic             fault,
  output logic [1:0]       err,
  stack_ctrl_if.master     mem
);

  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_POP     = 3'd2;
  localparam logic [2:0] OP_BINOP   = 3'd3;
  localparam logic [2:0] OP_REPLACE = 3'd4;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_OVER  = 2'b01;
  localparam logic [1:0] ERR_UNDER = 2'b10;

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] sp_q, sp_n;
  logic [WIDTH:0]   depth_q, depth_n;
  logic [1:0]       err_q, err_n;

  logic             is_empty, is_full, has_two;
  logic             issue;

  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == (WIDTH+1)'(SIZE));
  assign has_two  = (depth_q >= (WIDTH+1)'(2));

  // An op is only acted on in RUN without a competing clear.
  assign issue = op_valid && (state_q == RUN) && !clear;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      sp_q    <= '0;
      depth_q <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_n;
      sp_q    <= sp_n;
      depth_q <= depth_n;
      err_q   <= err_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    sp_n    = sp_q;
    depth_n = depth_q;
    err_n   = err_q;
    if (state_q == FAULT) begin
      if (clear) begin
        state_n = RUN;
        err_n   = ERR_NONE;
      end
    end else if (issue) begin
      unique case (op)
        OP_PUSH: begin
          if (is_full) begin
            state_n = FAULT;
            err_n   = ERR_OVER;
          end else begin
            sp_n    = sp_q + WIDTH'(1);
            depth_n = depth_q + (WIDTH+1)'(1);
          end
        end
        OP_POP: begin
          if (is_empty) begin
            state_n = FAULT;
            err_n   = ERR_UNDER;
          end else begin
            sp_n    = sp_q - WIDTH'(1);
            depth_n = depth_q - (WIDTH+1)'(1);
          end
        end
        OP_BINOP: begin
          if (!has_two) begin
            state_n = FAULT;
            err_n   = ERR_UNDER;
          end else begin
            sp_n    = sp_q - WIDTH'(1);
            depth_n = depth_q - (WIDTH+1)'(1);
          end
        end
        OP_REPLACE: begin
          if (is_empty) begin
            state_n = FAULT;
            err_n   = ERR_UNDER;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic: write port is combinational from the current op; reset
  // masks the write so an edge under reset never commits an aborted op.
  always_comb begin
    mem.we           = 1'b0;
    mem.mem_din_addr = sp_q;
    mem.mem_din      = data_in;
    if (issue && !reset) begin
      unique case (op)
        OP_PUSH: begin
          mem.we           = !is_full;
          mem.mem_din_addr = sp_q;
        end
        OP_BINOP: begin
          // Result lands where NOS was; the old TOS slot becomes free.
          mem.we           = has_two;
          mem.mem_din_addr = sp_q - WIDTH'(2);
        end
        OP_REPLACE: begin
          mem.we           = !is_empty;
          mem.mem_din_addr = sp_q - WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Read addresses depend on registered sp only, so they move on edges.
  assign mem.mem_dout_addr0 = sp_q - WIDTH'(1);
  assign mem.mem_dout_addr1 = sp_q - WIDTH'(2);

  assign tos   = mem.mem_dout0;
  assign nos   = mem.mem_dout1;
  assign depth = depth_q;
  assign empty = is_empty;
  assign full  = is_full;
  assign fault = (state_q == FAULT);
  assign err   = err_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - self-checking bench for stack_ctrl against a queue model
module tb_stack_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [15:0] data_in;
  logic        clear;
  logic [15:0] tos, nos;
  logic [6:0]  depth;
  logic        empty, full, fault;
  logic [1:0]  err;

  int checks = 0;
  int errors = 0;

  stack_ctrl_if #(.WIDTH(6)) mif ();

  stack_ctrl #(.WIDTH(6), .SIZE(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op       (op),
    .data_in  (data_in),
    .clear    (clear),
    .tos      (tos),
    .nos      (nos),
    .depth    (depth),
    .empty    (empty),
    .full     (full),
    .fault    (fault),
    .err      (err),
    .mem      (mif.master)
  );

  always #5 clk = ~clk;

  // Stack RAM: async read, write on posedge
  logic [15:0] mem [64] = '{default: 16'h0000};
  assign mif.mem_dout0 = mem[mif.mem_dout_addr0];
  assign mif.mem_dout1 = mem[mif.mem_dout_addr1];
  always @(posedge clk) if (mif.we) mem[mif.mem_din_addr] <= mif.mem_din;

  // Reference model: stack contents as a queue, plus sticky fault/err
  logic [15:0] stk [$];
  logic        m_fault;
  logic [1:0]  m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input logic [2:0] o, input int n);
    case (o)
      3'd1: return n < 64;
      3'd2, 3'd4: return n >= 1;
      3'd3: return n >= 2;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit writes(input logic [2:0] o);
    return (o == 3'd1) || (o == 3'd3) || (o == 3'd4);
  endfunction

  task automatic check_state();
    int n;
    n = stk.size();
    chk("depth", depth, n);
    chk("empty", empty, n == 0);
    chk("full", full, n == 64);
    chk("fault", fault, m_fault);
    chk("err", err, m_err);
    if (n >= 1) begin
      chk("tos", tos, stk[n-1]);
      chk("addr0", mif.mem_dout_addr0, (n + 63) % 64);
    end
    if (n >= 2) chk("nos", nos, stk[n-2]);
  endtask

  task automatic model_reset();
    stk.delete();
    m_fault = 1'b0;
    m_err   = 2'b00;
  endtask

  task automatic step(input logic v, input logic [2:0] o, input logic [15:0] d, input logic c);
    int  n;
    bit  act;
    bit  ok;
    bit  exp_we;
    @(negedge clk);
    op_valid = v; op = o; data_in = d; clear = c;
    #1;
    n      = stk.size();
    act    = v && !m_fault && !c;
    ok     = legal(o, n);
    exp_we = act && ok && writes(o);
    chk("we", mif.we, exp_we);
    if (exp_we) begin
      chk("wdata", mif.mem_din, d);
      case (o)
        3'd1: chk("waddr_push", mif.mem_din_addr, n % 64);
        3'd3: chk("waddr_binop", mif.mem_din_addr, (n + 62) % 64);
        default: chk("waddr_repl", mif.mem_din_addr, (n + 63) % 64);
      endcase
    end
    @(posedge clk);
    if (m_fault) begin
      if (c) begin
        m_fault = 1'b0;
        m_err   = 2'b00;
      end
    end else if (act) begin
      if (!ok) begin
        m_fault = 1'b1;
        m_err   = (o == 3'd1) ? 2'b01 : 2'b10;
      end else begin
        case (o)
          3'd1: stk.push_back(d);
          3'd2: void'(stk.pop_back());
          3'd3: begin void'(stk.pop_back()); stk[n-2] = d; end
          3'd4: stk[n-1] = d;
          default: ;
        endcase
      end
    end
    #1;
    check_state();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; op_valid = 1'b0; op = 3'd0; data_in = '0; clear = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check_state();
  endtask

  initial begin
    logic [15:0] old;
    int          idx;
    reset = 1'b1; op_valid = 1'b0; op = 3'd0; data_in = '0; clear = 1'b0;
    model_reset();
    #2;
    chk("rst_we", mif.we, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_depth", depth, 0);
    @(negedge clk);
    reset = 1'b0;

    // PUSH / PUSH / POP
    step(1, 3'd1, 16'h1111, 0);
    step(1, 3'd1, 16'h2222, 0);
    chk("tp1_depth", depth, 2);
    chk("tp1_tos", tos, 16'h2222);
    chk("tp1_nos", nos, 16'h1111);
    step(1, 3'd2, 16'h0000, 0);
    chk("tp1_tos_pop", tos, 16'h1111);

    // BINOP and REPLACE
    do_reset();
    step(1, 3'd1, 16'd3, 0);
    step(1, 3'd1, 16'd4, 0);
    step(1, 3'd3, 16'd7, 0);
    chk("tp2_depth", depth, 1);
    chk("tp2_tos", tos, 16'd7);
    chk("tp2_mem0", mem[0], 16'd7);
    step(1, 3'd4, 16'd9, 0);
    chk("tp2_repl", tos, 16'd9);

    // Fill, overflow, ignore in FAULT, clear
    do_reset();
    for (int i = 0; i < 64; i++) step(1, 3'd1, 16'(i), 0);
    chk("tp3_full", full, 1'b1);
    chk("tp3_tos", tos, 16'd63);
    chk("tp3_sp_wrap", mif.mem_dout_addr0, 6'd63);
    step(1, 3'd1, 16'hDEAD, 0);
    chk("tp3_fault", fault, 1'b1);
    chk("tp3_err", err, 2'b01);
    chk("tp3_depth", depth, 64);
    chk("tp3_mem0", mem[0], 16'd0);
    step(1, 3'd2, 16'h0000, 0);
    chk("tp3_ign_depth", depth, 64);
    step(0, 3'd0, 16'h0000, 1);
    chk("tp3_clear", fault, 1'b0);
    step(1, 3'd2, 16'h0000, 0);
    chk("tp3_tos62", tos, 16'd62);

    // Underflow traps
    do_reset();
    step(1, 3'd2, 16'h0000, 0);
    chk("tp4_fault", fault, 1'b1);
    chk("tp4_err", err, 2'b10);
    step(0, 3'd0, 16'h0000, 1);
    step(1, 3'd1, 16'd5, 0);
    step(1, 3'd3, 16'hBEEF, 0);
    chk("tp4_binop_err", err, 2'b10);
    chk("tp4_tos", tos, 16'd5);
    step(0, 3'd0, 16'h0000, 1);

    // clear beats a same-cycle PUSH
    step(1, 3'd1, 16'hAAAA, 1);
    chk("tp5_depth", depth, 1);

    // Async reset in the middle of a PUSH
    step(1, 3'd1, 16'h0101, 0);
    idx = stk.size();
    old = mem[idx];
    @(negedge clk);
    op_valid = 1'b1; op = 3'd1; data_in = 16'h5A5A; clear = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("tp6_we", mif.we, 1'b0);
    chk("tp6_depth", depth, 0);
    chk("tp6_empty", empty, 1'b1);
    chk("tp6_fault", fault, 1'b0);
    @(posedge clk);
    #1;
    chk("tp6_nowrite", mem[idx], old);
    @(negedge clk);
    op_valid = 1'b0; op = 3'd0;
    reset = 1'b0;
    model_reset();
    #1;
    check_state();

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      int          r;
      logic [2:0]  o;
      logic        c;
      r = $urandom_range(0, 99);
      if (r < 50) o = 3'd1;
      else if (r < 70) o = 3'd2;
      else if (r < 82) o = 3'd3;
      else if (r < 94) o = 3'd4;
      else o = 3'($urandom_range(5, 7));
      c = m_fault ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      step($urandom_range(0, 7) != 0, o, 16'($urandom), c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Pointer and control unit for the CPU data stack. It owns the stack pointer and depth counter, and drives the 2-read/1-write stack memory's address, write-enable and write-data ports. It returns top-of-stack (TOS) and next-on-stack (NOS) to the datapath. Illegal operations are trapped into a sticky fault state.

## Interface
Parameters:
- WIDTH, 6, pointer width; memory address width
- SIZE, 64, stack depth in words; must equal 2**WIDTH

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- op_valid  in  1  op present this cycle
- op  in  3  0 NOP, 1 PUSH, 2 POP, 3 BINOP (pop two, push one), 4 REPLACE (overwrite TOS); 5-7 treated as NOP
- data_in  in  16  write value for PUSH/BINOP/REPLACE
- clear  in  1  leave FAULT, clear err
- tos  out  16  value at sp-1 (undefined when depth=0)
- nos  out  16  value at sp-2 (undefined when depth<2)
- depth  out  WIDTH+1  words on stack, 0..SIZE
- empty / full  out  1 each  depth==0 / depth==SIZE
- fault  out  1  state==FAULT
- err  out  2  00 none, 01 overflow, 10 underflow
- mem_dout_addr0, mem_dout_addr1  out  WIDTH  read addresses
- mem_dout0, mem_dout1  in  16  async read data
- we  out  1  memory write enable
- mem_din_addr  out  WIDTH  write address
- mem_din  out  16  write data

## Operation
- Registers: sp (WIDTH bits, next free slot), depth (WIDTH+1 bits), state {RUN, FAULT}, err.
- Read addresses are combinational from sp: addr0 = sp-1, addr1 = sp-2, both mod 2**WIDTH. tos = mem_dout0, nos = mem_dout1.
- Legality in RUN with op_valid:
  - PUSH needs depth<SIZE.
  - POP and REPLACE need depth>=1.
  - BINOP needs depth>=2.
- Legal ops:
  - PUSH: we=1, addr=sp, din=data_in; sp+=1, depth+=1.
  - POP: no write; sp-=1, depth-=1.
  - BINOP: we=1, addr=sp-2, din=data_in; sp-=1, depth-=1.
  - REPLACE: we=1, addr=sp-1, din=data_in; sp and depth unchanged.
- Illegal op: no write, sp and depth unchanged. state→FAULT; err=01 for PUSH on full, 10 for any underflow.
- FAULT: all ops ignored (we=0). clear=1 → RUN, err=00 at next edge; sp and depth are kept.
- clear in RUN: no effect on sp/depth. If clear and op_valid are asserted in the same cycle, clear wins and the op is discarded.
- sp arithmetic wraps mod 2**WIDTH. depth never wraps, because illegal ops are trapped.
- we, mem_din_addr and mem_din are combinational from op, data_in, state, depth and sp. we is forced to 0 while reset=1.

## Timing
- Reset (async, immediate): sp=0, depth=0, state=RUN, err=00. Therefore empty=1, full=0, fault=0, we=0.
- Reset asserted mid-operation aborts the op; no memory write occurs at that edge.
- Zero-cycle issue: one op per cycle, no backpressure.
- An op sampled at edge k updates memory and sp at edge k. tos/nos reflect the result combinationally after edge k; read-after-write latency is 0 cycles.
- fault and err assert the cycle after the illegal op's edge. They deassert the cycle after clear.
- The address ports change only on clock edges; there are no combinational paths from op to the read addresses.

## Test plan
- Reset, then PUSH 0x1111, PUSH 0x2222 → depth=2, tos=0x2222, nos=0x1111; POP → depth=1, tos=0x1111.
- PUSH 3, PUSH 4, BINOP data_in=7 → depth=1, tos=7, memory[0]=7; REPLACE 9 → tos=9, depth=1.
- 64 PUSHes of value i → full=1, tos=63, sp=0 (wrapped). The 65th PUSH → fault=1, err=01, depth=64, memory[0] still 0. POP in FAULT → ignored. clear → fault=0, then POP → tos=62.
- Reset, then POP → fault=1, err=10, we=0. BINOP with depth=1 (after clear, PUSH 5) → err=10, tos=5.
- clear and PUSH in the same cycle while in RUN → depth unchanged, we=0.
- Assert reset asynchronously mid-cycle during a PUSH → outputs return to reset values immediately, no write occurs, and depth=0 after release.
